// File: rtl/inv_bank.sv
// Per-channel invert/pass-through bank feeding a DEPTH-entry valid/ready FIFO.
// Optional macro INV_BANK_PARITY_EN adds out_par (per-channel even parity stored with each word).
module inv_bank #(
   parameter int WIDTH = 8,
   parameter int CH    = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       mode_we,
   input  logic [CH-1:0]              mode_din,
   output logic [CH-1:0]              mode_q,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CH*WIDTH-1:0]        in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CH*WIDTH-1:0]        out_data,
`ifdef INV_BANK_PARITY_EN
   output logic [CH-1:0]              out_par,
`endif
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int DW = CH * WIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
`ifdef INV_BANK_PARITY_EN
   localparam int EW = DW + CH;
`else
   localparam int EW = DW;
`endif

   logic [CH-1:0] r_mode;
   logic [LW-1:0] r_level;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [EW-1:0] r_head;
   logic [EW-1:0] r_mem [DEPTH];

   logic [DW-1:0] w_word;
   logic [EW-1:0] w_entry;
   logic [EW-1:0] w_head_nxt;
   logic [PW-1:0] w_rd_nxt;
   logic          w_push;
   logic          w_pop;
   logic          w_head_ld;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < CH; i++) begin
         w_word[i*WIDTH +: WIDTH] = r_mode[i] ? ~in_data[i*WIDTH +: WIDTH]
                                              :  in_data[i*WIDTH +: WIDTH];
      end
   end

`ifdef INV_BANK_PARITY_EN
   logic [CH-1:0] w_par;
   always_comb begin
      w_par = '0;
      for (int i = 0; i < CH; i++) begin
         w_par[i] = ^w_word[i*WIDTH +: WIDTH];
      end
   end
   assign w_entry = {w_par, w_word};
   assign out_par = r_head[EW-1:DW];
`else
   assign w_entry = w_word;
`endif

   // Flush discards any handshake in the same cycle.
   assign w_push   = in_valid && in_ready && !flush;
   assign w_pop    = out_valid && out_ready && !flush;
   assign w_rd_nxt = r_rd_ptr + 1'b1;

   // The head register mirrors the FIFO head so out_data holds its last value once empty.
   always_comb begin
      w_head_ld  = 1'b0;
      w_head_nxt = w_entry;
      if (w_push && ((r_level == '0) || (w_pop && (r_level == LW'(1))))) begin
         w_head_ld = 1'b1;
      end else if (w_pop && (r_level > LW'(1))) begin
         w_head_ld  = 1'b1;
         w_head_nxt = r_mem[w_rd_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode   <= '0;
         r_level  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_head   <= '0;
      end else begin
         if (mode_we) r_mode <= mode_din;
         if (flush) begin
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + 1'b1;
               2'b01:   r_level <= r_level - 1'b1;
               default: r_level <= r_level;
            endcase
            if (w_head_ld) r_head <= w_head_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_entry;
   end

   assign mode_q    = r_mode;
   assign level     = r_level;
   assign in_ready  = (r_level != LW'(DEPTH));
   assign out_valid = (r_level != '0);
   assign out_data  = r_head[DW-1:0];

endmodule
